// File: rtl/resp_merge_ordered_pkg.sv
// rtl/resp_merge_ordered_pkg.sv - shared constants and helpers for the ordered response merger
package resp_merge_ordered_pkg;

    // Default queue depths (log2)
    localparam int RESP_MERGE_CHAN_Q_LOG_DEPTH = 3;
    localparam int RESP_MERGE_TAG_Q_LOG_DEPTH  = 5;
    localparam int RESP_MERGE_OUT_Q_LOG_DEPTH  = 2;

    // Merger state encoding
    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    // Width of a channel index; a single channel still needs one bit
    function automatic int chan_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/resp_merge_chan_slice.sv
// rtl/resp_merge_chan_slice.sv - one channel: response FIFO, pending-tag count, orphan detect
module resp_merge_chan_slice
    import resp_merge_ordered_pkg::*;
#(
    parameter int DATA_WIDTH = 512,
    parameter int SIZE_W     = 6,
    parameter int LOG_DEPTH  = RESP_MERGE_CHAN_Q_LOG_DEPTH,
    parameter int CNT_W      = RESP_MERGE_TAG_Q_LOG_DEPTH + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [SIZE_W-1:0]     in_size,
    output logic                  in_ready,
    input  logic                  tag_inc,
    input  logic                  deq,
    output logic                  empty,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic [SIZE_W-1:0]     head_size,
    output logic                  orphan
);
    logic                         full;
    logic                         accept;
    logic                         enq;
    logic [CNT_W-1:0]             pending;
    logic [DATA_WIDTH+SIZE_W-1:0] head_word;

    // A response nobody asked for is swallowed so the channel never stalls on it
    assign accept   = rst_n && in_valid && !full;
    assign orphan   = accept && (pending == '0) && !tag_inc;
    assign enq      = accept && !orphan;
    assign in_ready = accept;

    assign head_data = head_word[SIZE_W +: DATA_WIDTH];
    assign head_size = head_word[SIZE_W-1:0];

    resp_merge_fifo #(
        .WIDTH     (DATA_WIDTH + SIZE_W),
        .LOG_DEPTH (LOG_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .enq      (enq),
        .enq_data ({in_data, in_size}),
        .deq      (deq),
        .head     (head_word),
        .empty    (empty),
        .full     (full)
    );

    // Pending tags for this channel: tags issued minus responses kept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            case ({tag_inc, enq})
                2'b10:   pending <= pending + 1'b1;
                2'b01:   pending <= pending - 1'b1;
                default: pending <= pending;
            endcase
        end
    end

endmodule

// File: rtl/resp_merge_fifo.sv
// rtl/resp_merge_fifo.sv - register-based synchronous FIFO with show-ahead head
module resp_merge_fifo #(
    parameter int WIDTH     = 8,
    parameter int LOG_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enq,
    input  logic [WIDTH-1:0] enq_data,
    input  logic             deq,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);
    localparam int DEPTH = 1 << LOG_DEPTH;

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [LOG_DEPTH:0] wr_ptr;
    logic [LOG_DEPTH:0] rd_ptr;
    logic               do_enq;
    logic               do_deq;

    // Extra pointer bit distinguishes full from empty when the indices match
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[LOG_DEPTH] != rd_ptr[LOG_DEPTH]) &&
                    (wr_ptr[LOG_DEPTH-1:0] == rd_ptr[LOG_DEPTH-1:0]);
    assign do_enq = enq && !full;
    assign do_deq = deq && !empty;
    assign head   = mem[rd_ptr[LOG_DEPTH-1:0]];

    // Pointer advance on enqueue/dequeue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_enq) wr_ptr <= wr_ptr + 1'b1;
            if (do_deq) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since the pointers gate visibility
    always_ff @(posedge clk) begin
        if (do_enq) mem[wr_ptr[LOG_DEPTH-1:0]] <= enq_data;
    end

endmodule

// File: rtl/resp_merge_ordered.sv
// rtl/resp_merge_ordered.sv - restores request order across memory channels; optional stats via RESP_MERGE_STATS_EN
module resp_merge_ordered
    import resp_merge_ordered_pkg::*;
#(
    parameter int NUM_CHANNELS     = 4,
    parameter int DATA_WIDTH       = 512,
    parameter int SIZE_W           = 6,
    parameter int CHAN_Q_LOG_DEPTH = RESP_MERGE_CHAN_Q_LOG_DEPTH,
    parameter int TAG_Q_LOG_DEPTH  = RESP_MERGE_TAG_Q_LOG_DEPTH,
    parameter int OUT_Q_LOG_DEPTH  = RESP_MERGE_OUT_Q_LOG_DEPTH,
    localparam int CH_W            = chan_idx_width(NUM_CHANNELS)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              enabled,
    input  logic                              flush,
    input  logic                              tag_valid,
    input  logic [CH_W-1:0]                   tag_channel,
    output logic                              tag_ready,
    input  logic [NUM_CHANNELS-1:0]           chan_resp_valid,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] chan_resp_data,
    input  logic [NUM_CHANNELS*SIZE_W-1:0]    chan_resp_size,
    output logic [NUM_CHANNELS-1:0]           chan_resp_ready,
    output logic                              resp_valid,
    output logic [DATA_WIDTH-1:0]             resp_data,
    output logic [SIZE_W-1:0]                 resp_size,
    input  logic                              resp_ready,
    output logic [TAG_Q_LOG_DEPTH:0]          outstanding,
    output logic                              busy,
    output logic                              err_orphan,
    output logic [31:0]                       stat_resp_cnt,
    output logic [31:0]                       stat_stall_cnt
);
    localparam int OUT_W = DATA_WIDTH + SIZE_W;

    logic [0:0]            state;
    logic                  tag_in_range;
    logic [CH_W-1:0]       tag_head;
    logic                  tag_empty;
    logic                  tag_full;
    logic [NUM_CHANNELS-1:0] chan_empty;
    logic [NUM_CHANNELS-1:0] chan_orphan;
    logic [DATA_WIDTH-1:0] chan_head_data [NUM_CHANNELS];
    logic [SIZE_W-1:0]     chan_head_size [NUM_CHANNELS];
    logic                  head_chan_empty;
    logic                  merge_fire;
    logic [OUT_W-1:0]      out_head;
    logic                  out_empty;
    logic                  out_full;
    logic                  out_deq;
    logic                  drained;
    logic                  flush_done;

    assign tag_in_range = ({1'b0, tag_channel} < (CH_W + 1)'(NUM_CHANNELS));
    assign tag_ready    = rst_n && (state == ST_RUN) && enabled && tag_valid &&
                          !tag_full && tag_in_range;

    resp_merge_fifo #(
        .WIDTH     (CH_W),
        .LOG_DEPTH (TAG_Q_LOG_DEPTH)
    ) u_tag_q (
        .clk      (clk),
        .rst_n    (rst_n),
        .enq      (tag_ready),
        .enq_data (tag_channel),
        .deq      (merge_fire),
        .head     (tag_head),
        .empty    (tag_empty),
        .full     (tag_full)
    );

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
        resp_merge_chan_slice #(
            .DATA_WIDTH (DATA_WIDTH),
            .SIZE_W     (SIZE_W),
            .LOG_DEPTH  (CHAN_Q_LOG_DEPTH),
            .CNT_W      (TAG_Q_LOG_DEPTH + 1)
        ) u_slice (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (chan_resp_valid[c]),
            .in_data   (chan_resp_data[c*DATA_WIDTH +: DATA_WIDTH]),
            .in_size   (chan_resp_size[c*SIZE_W +: SIZE_W]),
            .in_ready  (chan_resp_ready[c]),
            .tag_inc   (tag_ready && (tag_channel == CH_W'(c))),
            .deq       (merge_fire && (tag_head == CH_W'(c))),
            .empty     (chan_empty[c]),
            .head_data (chan_head_data[c]),
            .head_size (chan_head_size[c]),
            .orphan    (chan_orphan[c])
        );
    end

    // Head tag picks its channel queue directly by index
    assign head_chan_empty = chan_empty[tag_head];
    assign merge_fire      = !tag_empty && !head_chan_empty && !out_full;

    resp_merge_fifo #(
        .WIDTH     (OUT_W),
        .LOG_DEPTH (OUT_Q_LOG_DEPTH)
    ) u_out_q (
        .clk      (clk),
        .rst_n    (rst_n),
        .enq      (merge_fire),
        .enq_data ({chan_head_data[tag_head], chan_head_size[tag_head]}),
        .deq      (out_deq),
        .head     (out_head),
        .empty    (out_empty),
        .full     (out_full)
    );

    // While flushing the output queue drains unconditionally and is discarded
    assign resp_valid = (state == ST_RUN) && enabled && !out_empty;
    assign resp_data  = resp_valid ? out_head[SIZE_W +: DATA_WIDTH] : '0;
    assign resp_size  = resp_valid ? out_head[SIZE_W-1:0] : '0;
    assign out_deq    = (resp_valid && resp_ready) || ((state == ST_FLUSH) && !out_empty);

    assign drained    = tag_empty && (&chan_empty) && out_empty && (outstanding == '0);
    assign flush_done = (state == ST_FLUSH) && drained;
    assign busy       = (state != ST_RUN) || !tag_empty || !(&chan_empty) || !out_empty;

    // Tags accepted but not yet merged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= '0;
        end else begin
            case ({tag_ready, merge_fire})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // RUN/FLUSH control; a flush request while already flushing has no effect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            case (state)
                ST_RUN:   if (flush)   state <= ST_FLUSH;
                ST_FLUSH: if (drained) state <= ST_RUN;
                default:               state <= ST_RUN;
            endcase
        end
    end

    // Sticky orphan flag; a fresh orphan outranks the clear on leaving FLUSH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_orphan <= 1'b0;
        end else if (|chan_orphan) begin
            err_orphan <= 1'b1;
        end else if (flush_done) begin
            err_orphan <= 1'b0;
        end
    end

`ifdef RESP_MERGE_STATS_EN
    logic [31:0] resp_cnt_q;
    logic [31:0] stall_cnt_q;

    // Saturating delivered-response and head-stall counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else if (flush_done) begin
            resp_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (resp_valid && resp_ready && (resp_cnt_q != '1))
                resp_cnt_q <= resp_cnt_q + 1'b1;
            if (!tag_empty && head_chan_empty && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign stat_resp_cnt  = resp_cnt_q;
    assign stat_stall_cnt = stall_cnt_q;
`else
    assign stat_resp_cnt  = '0;
    assign stat_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_resp_merge_ordered.sv
// tb/tb_resp_merge_ordered.sv - self-checking bench for resp_merge_ordered
module tb_resp_merge_ordered;
    localparam int NCH = 4;
    localparam int DW  = 32;
    localparam int SW  = 6;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             enabled, flush, tag_valid, tag_ready, resp_valid, resp_ready, busy, err_orphan;
    logic [1:0]       tag_channel;
    logic [NCH-1:0]   chan_resp_valid, chan_resp_ready;
    logic [NCH*DW-1:0] chan_resp_data;
    logic [NCH*SW-1:0] chan_resp_size;
    logic [DW-1:0]    resp_data;
    logic [SW-1:0]    resp_size;
    logic [5:0]       outstanding;
    logic [31:0]      stat_resp_cnt, stat_stall_cnt;

    logic             tag_valid3, tag_ready3, resp_valid3, busy3, err_orphan3;
    logic [1:0]       tag_channel3;
    logic [2:0]       chan_resp_ready3;
    logic [DW-1:0]    resp_data3;
    logic [SW-1:0]    resp_size3;
    logic [5:0]       outstanding3;
    logic [31:0]      stat_resp_cnt3, stat_stall_cnt3;

    always #5 clk = ~clk;

    resp_merge_ordered #(.NUM_CHANNELS(NCH), .DATA_WIDTH(DW), .SIZE_W(SW)) u_dut (
        .clk(clk), .rst_n(rst_n), .enabled(enabled), .flush(flush),
        .tag_valid(tag_valid), .tag_channel(tag_channel), .tag_ready(tag_ready),
        .chan_resp_valid(chan_resp_valid), .chan_resp_data(chan_resp_data),
        .chan_resp_size(chan_resp_size), .chan_resp_ready(chan_resp_ready),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_size(resp_size),
        .resp_ready(resp_ready), .outstanding(outstanding), .busy(busy),
        .err_orphan(err_orphan), .stat_resp_cnt(stat_resp_cnt), .stat_stall_cnt(stat_stall_cnt)
    );

    resp_merge_ordered #(.NUM_CHANNELS(3), .DATA_WIDTH(DW), .SIZE_W(SW)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .enabled(1'b1), .flush(1'b0),
        .tag_valid(tag_valid3), .tag_channel(tag_channel3), .tag_ready(tag_ready3),
        .chan_resp_valid(3'b000), .chan_resp_data({3*DW{1'b0}}),
        .chan_resp_size({3*SW{1'b0}}), .chan_resp_ready(chan_resp_ready3),
        .resp_valid(resp_valid3), .resp_data(resp_data3), .resp_size(resp_size3),
        .resp_ready(1'b1), .outstanding(outstanding3), .busy(busy3),
        .err_orphan(err_orphan3), .stat_resp_cnt(stat_resp_cnt3), .stat_stall_cnt(stat_stall_cnt3)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expired(input string name);
        total++;
        bad++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Reference model: tag order queue plus per-channel arrival lists
    logic [37:0] got_q[$];
    int          tq[$];
    logic [37:0] cmem [NCH][1024];
    int          cwr [NCH];
    int          crd [NCH];
    int          pend[NCH];
    bit          model_on = 1'b0;

    always @(negedge clk) begin
        int          ch;
        logic [37:0] exp;
        if (rst_n) begin
            if (tag_valid && tag_ready) begin
                tq.push_back(int'(tag_channel));
                pend[tag_channel]++;
            end
            for (int c = 0; c < NCH; c++) begin
                if (chan_resp_valid[c] && chan_resp_ready[c] && pend[c] > 0) begin
                    cmem[c][cwr[c] % 1024] = {chan_resp_data[c*DW +: DW], chan_resp_size[c*SW +: SW]};
                    cwr[c]++;
                    pend[c]--;
                end
            end
            if (resp_valid && resp_ready) begin
                if (!model_on) begin
                    got_q.push_back({resp_data, resp_size});
                end else if (tq.size() == 0) begin
                    check("rand_extra_beat", 1, 0);
                end else begin
                    ch = tq.pop_front();
                    if (crd[ch] < cwr[ch]) begin
                        exp = cmem[ch][crd[ch] % 1024];
                        crd[ch]++;
                        check("rand_order", {resp_data, resp_size}, exp);
                    end else begin
                        check("rand_early_beat", 1, 0);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_tag(input int ch);
        int n = 0;
        tag_valid   = 1'b1;
        tag_channel = 2'(ch);
        @(negedge clk);
        while (!tag_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!tag_ready) expired("send_tag");
        tick();
        tag_valid = 1'b0;
    endtask

    task automatic send_resp(input int ch, input logic [DW-1:0] d, input logic [SW-1:0] s);
        int n = 0;
        chan_resp_valid[ch]          = 1'b1;
        chan_resp_data[ch*DW +: DW]  = d;
        chan_resp_size[ch*SW +: SW]  = s;
        @(negedge clk);
        while (!chan_resp_ready[ch] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!chan_resp_ready[ch]) expired("send_resp");
        tick();
        chan_resp_valid[ch] = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk);
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(name, busy, 0);
        tick();
    endtask

    typedef struct {
        logic       en;
        logic       tv;
        logic [1:0] tch;
        logic [3:0] crv;
        logic       exp_tr;
        logic [3:0] exp_crr;
    } vec_t;

    vec_t vecs[6];
    logic exp3[4];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000};
        vecs[1] = '{1'b0, 1'b1, 2'd1, 4'b0000, 1'b0, 4'b0000};
        vecs[2] = '{1'b1, 1'b0, 2'd2, 4'b0001, 1'b0, 4'b0001};
        vecs[3] = '{1'b1, 1'b1, 2'd3, 4'b1010, 1'b1, 4'b1010};
        vecs[4] = '{1'b0, 1'b0, 2'd0, 4'b1111, 1'b0, 4'b1111};
        vecs[5] = '{1'b1, 1'b1, 2'd2, 4'b0110, 1'b1, 4'b0110};
        exp3[0] = 1'b1; exp3[1] = 1'b1; exp3[2] = 1'b1; exp3[3] = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            cwr[c] = 0; crd[c] = 0; pend[c] = 0;
        end

        // Reset: outputs quiet even with inputs asserted
        rst_n = 1'b0; enabled = 1'b1; flush = 1'b0; resp_ready = 1'b1;
        tag_valid = 1'b1; tag_channel = 2'd0; tag_valid3 = 1'b1; tag_channel3 = 2'd0;
        chan_resp_valid = '1; chan_resp_data = '0; chan_resp_size = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_tag_ready", tag_ready, 0);
        check("rst_tag_ready3", tag_ready3, 0);
        check("rst_chan_ready", chan_resp_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_data", resp_data, 0);
        check("rst_busy", busy, 0);
        check("rst_outstanding", outstanding, 0);
        check("rst_err_orphan", err_orphan, 0);
        tag_valid = 1'b0; tag_valid3 = 1'b0; chan_resp_valid = '0;
        rst_n = 1'b1;
        tick();
        tick();

        // Table of combinational handshake vectors in idle RUN state
        for (int i = 0; i < 6; i++) begin
            enabled = vecs[i].en; tag_valid = vecs[i].tv;
            tag_channel = vecs[i].tch; chan_resp_valid = vecs[i].crv;
            #1;
            check($sformatf("vec%0d_tag_ready", i), tag_ready, vecs[i].exp_tr);
            check($sformatf("vec%0d_chan_ready", i), chan_resp_ready, vecs[i].exp_crr);
            tag_valid = 1'b0; chan_resp_valid = '0; enabled = 1'b1;
        end
        for (int i = 0; i < 4; i++) begin
            tag_valid3 = 1'b1; tag_channel3 = 2'(i);
            #1;
            check($sformatf("nch3_tag%0d_ready", i), tag_ready3, exp3[i]);
            tag_valid3 = 1'b0;
        end
        tick();

        // Reordering: tags ch2,ch0,ch2 then responses ch0 A, ch2 B, ch2 C
        got_q.delete();
        send_tag(2); send_tag(0); send_tag(2);
        check("ord_outstanding3", outstanding, 3);
        send_resp(0, 32'hAAAA_0001, 6'd1);
        send_resp(2, 32'hBBBB_0002, 6'd2);
        send_resp(2, 32'hCCCC_0003, 6'd3);
        wait_idle("ord_idle");
        check("ord_count", got_q.size(), 3);
        if (got_q.size() == 3) begin
            check("ord_first_B", got_q[0], {32'hBBBB_0002, 6'd2});
            check("ord_second_A", got_q[1], {32'hAAAA_0001, 6'd1});
            check("ord_third_C", got_q[2], {32'hCCCC_0003, 6'd3});
        end
        check("ord_outstanding0", outstanding, 0);

        // Latency: response accepted in cycle N appears in N+2, idle in N+3
        got_q.delete();
        send_tag(1);
        tick(); tick();
        chan_resp_valid[1] = 1'b1; chan_resp_data[DW +: DW] = 32'h1A7E_0C11; chan_resp_size[SW +: SW] = 6'd9;
        @(negedge clk);
        check("lat_chan_ready", chan_resp_ready[1], 1);
        check("lat_n0_valid", resp_valid, 0);
        tick();
        chan_resp_valid[1] = 1'b0;
        @(negedge clk);
        check("lat_n1_valid", resp_valid, 0);
        @(negedge clk);
        check("lat_n2_valid", resp_valid, 1);
        check("lat_n2_data", {resp_data, resp_size}, {32'h1A7E_0C11, 6'd9});
        @(negedge clk);
        check("lat_n3_busy", busy, 0);
        tick();
        got_q.delete();

        // Orphan on ch3: consumed, flagged, nothing delivered
        chan_resp_valid[3] = 1'b1; chan_resp_data[3*DW +: DW] = 32'hDEAD_0003;
        @(negedge clk);
        check("orph_ready", chan_resp_ready, 4'b1000);
        tick();
        chan_resp_valid[3] = 1'b0;
        check("orph_err", err_orphan, 1);
        repeat (4) tick();
        check("orph_sticky", err_orphan, 1);
        check("orph_busy", busy, 0);
        check("orph_none", got_q.size(), 0);

        // Tag queue full at 32; one merge frees a slot
        for (int i = 0; i < 32; i++) send_tag(0);
        check("fill_outstanding32", outstanding, 32);
        tag_valid = 1'b1; tag_channel = 2'd1;
        #1;
        check("fill_33rd_ready", tag_ready, 0);
        chan_resp_valid[0] = 1'b1; chan_resp_data[0 +: DW] = 32'hF000_0000; chan_resp_size[0 +: SW] = 6'd5;
        @(negedge clk);
        check("fill_n0_ready", tag_ready, 0);
        tick();
        chan_resp_valid[0] = 1'b0;
        @(negedge clk);
        check("fill_n1_ready", tag_ready, 0);
        @(negedge clk);
        check("fill_n2_ready", tag_ready, 1);
        tick();
        tag_valid = 1'b0;
        check("fill_outstanding_after", outstanding, 32);
        for (int i = 1; i < 32; i++) send_resp(0, 32'hF000_0000 + i, 6'(i));
        send_resp(1, 32'hF111_1111, 6'd7);
        wait_idle("fill_idle");
        check("fill_count", got_q.size(), 33);
        if (got_q.size() == 33) begin
            check("fill_first", got_q[0], {32'hF000_0000, 6'd5});
            check("fill_last", got_q[32], {32'hF111_1111, 6'd7});
        end
        check("fill_outstanding0", outstanding, 0);

        // enabled=0 holds merged responses until re-enabled
        got_q.delete();
        send_tag(0); send_tag(1);
        enabled = 1'b0;
        send_resp(0, 32'h0E00_0000, 6'd10);
        send_resp(1, 32'h0E11_1111, 6'd11);
        repeat (5) tick();
        check("en_valid", resp_valid, 0);
        check("en_data", resp_data, 0);
        check("en_outstanding", outstanding, 0);
        check("en_busy", busy, 1);
        check("en_none", got_q.size(), 0);
        enabled = 1'b1;
        wait_idle("en_idle");
        check("en_count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            check("en_first", got_q[0], {32'h0E00_0000, 6'd10});
            check("en_second", got_q[1], {32'h0E11_1111, 6'd11});
        end

        // Flush with 3 tags outstanding and one response in the output queue
        got_q.delete();
        send_tag(0); send_tag(1); send_tag(2); send_tag(3);
        enabled = 1'b0;
        send_resp(0, 32'h5A5A_0000, 6'd12);
        repeat (3) tick();
        check("fl_outstanding3", outstanding, 3);
        flush = 1'b1;
        tick();
        flush = 1'b0; enabled = 1'b1;
        check("fl_valid", resp_valid, 0);
        check("fl_busy", busy, 1);
        tag_valid = 1'b1; tag_channel = 2'd0;
        #1;
        check("fl_tag_ready", tag_ready, 0);
        tag_valid = 1'b0;
        send_resp(1, 32'h5A5A_0001, 6'd13);
        send_resp(2, 32'h5A5A_0002, 6'd14);
        send_resp(3, 32'h5A5A_0003, 6'd15);
        wait_idle("fl_idle");
        check("fl_err_cleared", err_orphan, 0);
        check("fl_none", got_q.size(), 0);
        check("fl_outstanding0", outstanding, 0);
        tag_valid = 1'b1; tag_channel = 2'd2;
        #1;
        check("fl_back_in_run", tag_ready, 1);
        tag_valid = 1'b0;
        tick();

        // Randomized traffic against the reference model
        tq.delete();
        for (int c = 0; c < NCH; c++) begin
            cwr[c] = 0; crd[c] = 0; pend[c] = 0;
        end
        model_on = 1'b1;
        for (int k = 0; k < 1500; k++) begin
            tag_valid   = ($urandom_range(0, 99) < 60);
            tag_channel = 2'($urandom_range(0, 3));
            resp_ready  = ($urandom_range(0, 99) < 75);
            for (int c = 0; c < NCH; c++) begin
                chan_resp_valid[c] = (pend[c] > 0) && ($urandom_range(0, 99) < 50);
                chan_resp_data[c*DW +: DW] = $urandom;
                chan_resp_size[c*SW +: SW] = 6'($urandom);
            end
            tick();
        end
        tag_valid = 1'b0; resp_ready = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            int left = 0;
            for (int c = 0; c < NCH; c++) begin
                left += pend[c];
                chan_resp_valid[c] = (pend[c] > 0);
                chan_resp_data[c*DW +: DW] = $urandom;
                chan_resp_size[c*SW +: SW] = 6'($urandom);
            end
            if (left == 0) break;
            tick();
        end
        chan_resp_valid = '0;
        wait_idle("rand_idle");
        check("rand_all_delivered", tq.size(), 0);
        check("rand_err_orphan", err_orphan, 0);
        check("rand_outstanding0", outstanding, 0);
        model_on = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
